mealy_word_collector: RTL

- Downstream consumer of the 3-bit serial Mealy sequence detector.
- Watches the same serial bit stream as the detector and groups it into WORD_BITS-bit words aligned to the detector's frame (state A at every word boundary).
- Tags each word with the detector's match flag, sampled on the word's last bit.
- Buffers tagged words in a small FIFO with a valid/ready output, and keeps a saturating match counter plus a sticky overflow flag.

---
 rtl/mealy_word_collector_if.sv | 31 +++
 rtl/mealy_word_collector.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mealy_word_collector_if.sv
// Bus bundle for mealy_word_collector: serial bit input side plus the
// tagged-word FIFO output side and status.
interface mealy_word_collector_if #(
   parameter int unsigned WORD_BITS  = 3,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 8
);
   logic                          bit_in;
   logic                          bit_valid;
   logic                          det_flag;
   logic                          realign;
   logic [WORD_BITS-1:0]          out_word;
   logic                          out_flag;
   logic                          out_valid;
   logic                          out_ready;
   logic [CNT_W-1:0]              match_count;
   logic                          overflow;
   logic [$clog2(FIFO_DEPTH):0]   fifo_level;

   // Producer/consumer side (drives bits, accepts words)
   modport master (
      output bit_in, bit_valid, det_flag, realign, out_ready,
      input  out_word, out_flag, out_valid, match_count, overflow, fifo_level
   );

   // Collector side
   modport slave (
      input  bit_in, bit_valid, det_flag, realign, out_ready,
      output out_word, out_flag, out_valid, match_count, overflow, fifo_level
   );
endinterface

// File: rtl/mealy_word_collector.sv
// mealy_word_collector: groups the detector's serial stream into frame-aligned
// words, tags each with the detector match flag sampled on the last bit, and
// queues them in a small FIFO. Keeps a saturating match counter and a sticky
// overflow flag.
// Optional build macro MWC_MATCH_ONLY_EN: only flagged words enter the FIFO.
// WORD_BITS must be >= 3; FIFO_DEPTH must be a power of two >= 2.
module mealy_word_collector #(
   parameter int unsigned WORD_BITS  = 3,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 8
) (
   input logic                   clk,
   input logic                   rst,
   mealy_word_collector_if.slave bus
);
   localparam int unsigned PH_W  = $clog2(WORD_BITS);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(WORD_BITS - 1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef struct packed {
      logic                 flag;
      logic [WORD_BITS-1:0] word;
   } entry_t;

   logic [PH_W-1:0]      phase_q,  phase_d;
   logic [WORD_BITS-2:0] shift_q,  shift_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]     level_q,  level_d;
   logic [CNT_W-1:0]     count_q,  count_d;
   logic                 ovf_q,    ovf_d;
   entry_t               mem_q [FIFO_DEPTH];

   logic   word_done;
   logic   push_req;
   logic   push;
   logic   pop;
   logic   full;
   entry_t new_entry;

   // Control state register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q  <= '0;
         shift_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         shift_q  <= shift_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // FIFO storage; contents are only observable through the level-gated head
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wr_ptr_q] <= new_entry;
      end
   end

   // Next-state: framing, push/pop arbitration, counter and overflow
   always_comb begin
      // realign outranks completion, so a restart cycle never pushes
      word_done = bus.bit_valid && (phase_q == PH_LAST) && !bus.realign;
`ifdef MWC_MATCH_ONLY_EN
      push_req  = word_done && bus.det_flag;
`else
      push_req  = word_done;
`endif
      full      = (level_q == LVL_FULL);
      pop       = (level_q != '0) && bus.out_ready;
      // a full FIFO still accepts when the head leaves in the same cycle
      push      = push_req && (!full || pop);

      new_entry.flag = bus.det_flag;
      new_entry.word = {shift_q, bus.bit_in};

      phase_d = phase_q;
      shift_d = shift_q;
      if (bus.realign) begin
         phase_d = '0;
         shift_d = '0;
      end else if (bus.bit_valid) begin
         shift_d = {shift_q[WORD_BITS-3:0], bus.bit_in};
         phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
      end

      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

      level_d = level_q;
      if (push && !pop) begin
         level_d = level_q + LVL_W'(1);
      end else if (!push && pop) begin
         level_d = level_q - LVL_W'(1);
      end

      count_d = count_q;
      if (word_done && bus.det_flag && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_W'(1);
      end

      ovf_d = ovf_q | (push_req && !push);
   end

   // Outputs: head of FIFO (zero when empty) and status
   always_comb begin
      bus.out_valid   = (level_q != '0);
      bus.out_word    = '0;
      bus.out_flag    = 1'b0;
      if (level_q != '0) begin
         bus.out_word = mem_q[rd_ptr_q].word;
         bus.out_flag = mem_q[rd_ptr_q].flag;
      end
      bus.match_count = count_q;
      bus.overflow    = ovf_q;
      bus.fifo_level  = level_q;
   end
endmodule
